i8088_bus_responder: RTL and testbench
======================================

# i8088_bus_responder

Byte-wide memory/I/O responder for the Intel 8088 minimum-mode bus. It is the target side of the processor bus:
- latches the multiplexed address on ALE;
- decodes its window;
- drives AD during read cycles and captures AD during write cycles;
- optionally inserts wait states through a READY request.

It connects to the Peripheral side of the processor pin interface, plus the AD, A and ready pins.

## Interface
- `ADDR_BITS`, 10 — internal storage is 2**ADDR_BITS bytes; the low address bits index it.
- `BASE_ADDR`, 20'h00000 — window base; compared on bits [19:ADDR_BITS].
- `IO_SPACE`, 0 — 1 responds to I/O cycles (IOM=1), 0 responds to memory cycles (IOM=0).
- `WAIT_STATES`, 2 — cycles RDY is held low per selected transfer (0–15).

Ports:
- `CLK`  input  1  bus clock; single clock domain.
- `RESET`  input  1  asynchronous, active-high reset.
- `ALE`  input  1  address latch enable from the processor.
- `IOM`  input  1  1 = I/O cycle, 0 = memory cycle.
- `RD`  input  1  read strobe, active low.
- `WR`  input  1  write strobe, active low.
- `A`  input  12  address bits [19:8].
- `AD`  inout  8  multiplexed address[7:0]/data; driven only as specified below, otherwise Z.
- `RDY`  output  1  ready request to the processor; 1 = ready.

## Operation
State machine with states IDLE, ADDR, READ and WRITE. Address register `addr[19:0]`, read-data register `rdata[7:0]`, write-data register `wdata[7:0]`, wait counter `wcnt[3:0]`.

- **Any state, rising CLK with ALE=1:**
  - latch `addr <= {A, AD}`;
  - `sel = (IOM==IO_SPACE) && (addr[19:ADDR_BITS]==BASE_ADDR[19:ADDR_BITS])`, evaluated on the values being latched;
  - next state is ADDR if `sel`, else IDLE.
  - ALE takes priority over every other transition and aborts any cycle in progress; an aborted write is not committed.
- **IDLE:** hold; AD=Z.
- **ADDR:**
  - every cycle, `rdata <= mem[addr[ADDR_BITS-1:0]]`;
  - RD=0, WR=1 → READ, `wcnt <= WAIT_STATES`;
  - WR=0, RD=1 → WRITE, `wcnt <= WAIT_STATES`;
  - RD=0 and WR=0 → protocol violation: stay in ADDR, no drive, no write.
- **READ:**
  - AD driven with `rdata` combinationally while state==READ and RD=0;
  - RD=1 at a rising edge → IDLE.
- **WRITE:**
  - while WR=0, `wdata <= AD` every cycle;
  - WR=1 at a rising edge → `mem[addr] <= wdata`, then IDLE. The last byte sampled while WR was low is the one written.
- **Wait counter:** `wcnt` decrements by 1 per cycle in READ/WRITE and saturates at 0.
- **RDY:** `RDY = !((state==READ || state==WRITE) && wcnt!=0)`; it is combinational from registered state.
- Unselected cycles never drive AD or RDY low.
- Memory contents are not initialised by RESET.

## Timing
- **Reset values:** state=IDLE, AD=Z, RDY=1, addr=0, wcnt=0, rdata=0, wdata=0. Assertion takes effect immediately (asynchronous), including mid-READ: AD is released at once.
- **Address decode:** state is ADDR one cycle after the ALE edge.
- **Read path:**
  - READ is entered on the first edge that sees RD=0.
  - AD is valid from the first CLK after that edge and stays valid until RD=1 or the next state change.
  - Data is from `rdata`, loaded in ADDR no later than the cycle before entry.
- **RDY:** low for exactly WAIT_STATES cycles after entering READ/WRITE, then high. It is high on entry when WAIT_STATES=0.
- **Write commit:** one clock after WR is sampled high. A read in the following cycle of the same address returns the new byte.
- **Simultaneous events:**
  - ALE=1 together with a strobe → ALE wins.
  - RESET with anything → reset wins.

## Configuration
- `I8088_RESP_WAIT_EN` defined: the wait counter and RDY logic are compiled in, as above.
- Not defined: `wcnt` is removed, RDY is tied to 1, and WAIT_STATES is ignored. All other behaviour is unchanged.

## Test plan
- **Reset:** RESET=1 mid-READ driving 8'hA5 → AD=Z and RDY=1 within the same cycle; state IDLE after release.
- **Write then read:** memory write to 20'h00123 of 8'h5A (ALE, then WR low 3 cycles) → a subsequent read of 20'h00123 drives AD=8'h5A while RD=0.
- **Wait states:** macro defined, WAIT_STATES=2, read cycle → RDY=0 for exactly 2 cycles after READ entry, then 1; AD valid throughout RD low.
- **Decode:** IOM=1 cycle to 20'h00123 with IO_SPACE=0, and a memory cycle to 20'h00523 (outside the 1 KB window) → AD stays Z, RDY stays 1, memory unchanged.
- **Abort:** ALE pulse during WRITE before WR rises, followed by a read → the original byte is returned and the aborted write is never committed.
- **Macro off:** build without `I8088_RESP_WAIT_EN`, WAIT_STATES=2 → RDY constantly 1 and reads return correct data.

Source files
------------

// File: rtl/i8088_bus_responder.sv
// Byte-wide memory/I/O target for the 8088 minimum-mode bus: ALE address latch, window decode, AD read drive/write capture.
// Optional wait-state insertion on RDY is compiled in when I8088_RESP_WAIT_EN is defined.
module i8088_bus_responder #(
  parameter int          ADDR_BITS   = 10,
  parameter logic [19:0] BASE_ADDR   = 20'h00000,
  parameter bit          IO_SPACE    = 1'b0,
  parameter int          WAIT_STATES = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ALE,
  input  logic        IOM,
  input  logic        RD,
  input  logic        WR,
  input  logic [11:0] A,
  inout  wire  [7:0]  AD,
  output logic        RDY
);

  localparam int         DEPTH = 1 << ADDR_BITS;
  localparam logic [3:0] WS    = 4'(WAIT_STATES);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ADDR  = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;
  localparam logic [1:0] ST_WRITE = 2'd3;

  logic [1:0]  state;
  logic [19:0] addr;
  logic [7:0]  rdata;
  logic [7:0]  wdata;
  logic [7:0]  mem [0:DEPTH-1];

  logic [19:0]          addr_in;
  logic                 sel;
  logic                 win_hit;
  logic                 commit;
  logic                 drive;
  logic [ADDR_BITS-1:0] idx;

  // Decode uses the address being latched this edge, not the stale register.
  assign addr_in = {A, AD};
  assign sel     = (IOM == IO_SPACE) &&
                   (addr_in[19:ADDR_BITS] == BASE_ADDR[19:ADDR_BITS]);
  assign win_hit = (addr[19:ADDR_BITS] == BASE_ADDR[19:ADDR_BITS]);
  assign idx     = addr[ADDR_BITS-1:0];

  // ALE aborts a write in flight, so the commit is suppressed when it coincides.
  assign commit  = (state == ST_WRITE) && WR && !ALE && win_hit;
  assign drive   = (state == ST_READ) && !RD;
  assign AD      = drive ? rdata : 8'bz;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= ST_IDLE;
      addr  <= 20'h00000;
      rdata <= 8'h00;
      wdata <= 8'h00;
    end else if (ALE) begin
      addr  <= addr_in;
      state <= sel ? ST_ADDR : ST_IDLE;
    end else begin
      case (state)
        ST_ADDR: begin
          rdata <= mem[idx];
          if (!RD && WR) begin
            state <= ST_READ;
          end else if (RD && !WR) begin
            state <= ST_WRITE;
          end
        end
        ST_READ: begin
          if (RD) begin
            state <= ST_IDLE;
          end
        end
        ST_WRITE: begin
          if (!WR) begin
            wdata <= AD;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Storage is deliberately left out of reset; contents survive RESET.
  always_ff @(posedge CLK) begin
    if (commit && !RESET) begin
      mem[idx] <= wdata;
    end
  end

`ifdef I8088_RESP_WAIT_EN
  logic [3:0] wcnt;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wcnt <= 4'd0;
    end else if (!ALE && (state == ST_ADDR) && (RD != WR)) begin
      wcnt <= WS;
    end else if (((state == ST_READ) || (state == ST_WRITE)) && (wcnt != 4'd0)) begin
      wcnt <= wcnt - 4'd1;
    end
  end

  assign RDY = !(((state == ST_READ) || (state == ST_WRITE)) && (wcnt != 4'd0));
`else
  logic unused_ws;

  assign unused_ws = ^WS;
  assign RDY       = 1'b1;
`endif

endmodule

// File: tb/tb_i8088_bus_responder.sv
// Directed bench for i8088_bus_responder: read data checked through a scoreboard queue, RDY/AD release against constants.
// Expected RDY timing follows I8088_RESP_WAIT_EN as seen by this compile.
module tb_i8088_bus_responder;

  localparam int WS = 2;
`ifdef I8088_RESP_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET;
  logic        ALE;
  logic        IOM;
  logic        RD;
  logic        WR;
  logic [11:0] A;
  wire  [7:0]  AD;
  wire         RDY;

  logic        ad_oe;
  logic [7:0]  ad_drv;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q [$];
  logic [7:0] model [logic [19:0]];

  // A released AD bus floats up to 8'hFF through the pullups.
  assign AD = ad_oe ? ad_drv : 8'bz;
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_pu
      pullup (AD[gi]);
    end
  endgenerate

  i8088_bus_responder #(
    .ADDR_BITS   (10),
    .BASE_ADDR   (20'h00000),
    .IO_SPACE    (1'b0),
    .WAIT_STATES (WS)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .ALE   (ALE),
    .IOM   (IOM),
    .RD    (RD),
    .WR    (WR),
    .A     (A),
    .AD    (AD),
    .RDY   (RDY)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic expRdy(input int k);
    return !WAIT_EN || (k >= WS);
  endfunction

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic applyStimulus(input logic ale, input logic iom, input logic rd, input logic wr,
                               input logic [19:0] adr, input logic oe, input logic [7:0] drv);
    ALE    = ale;
    IOM    = iom;
    RD     = rd;
    WR     = wr;
    A      = adr[19:8];
    ad_oe  = oe;
    ad_drv = drv;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic doWrite(input logic [19:0] adr, input logic iom, input logic [7:0] data,
                         input bit sel, input string tag);
    applyStimulus(1'b1, iom, 1'b1, 1'b1, adr, 1'b1, adr[7:0]);
    tick();
    applyStimulus(1'b0, iom, 1'b1, 1'b0, adr, 1'b1, data);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput({tag, " wr rdy"}, {7'd0, RDY}, {7'd0, sel ? expRdy(k) : 1'b1});
    end
    applyStimulus(1'b0, iom, 1'b1, 1'b1, adr, 1'b1, data);
    tick();
    ad_oe = 1'b0;
    if (sel) model[adr] = data;
  endtask

  task automatic doRead(input logic [19:0] adr, input logic iom, input bit sel, input string tag);
    logic [7:0] expd;
    applyStimulus(1'b1, iom, 1'b1, 1'b1, adr, 1'b1, adr[7:0]);
    tick();
    applyStimulus(1'b0, iom, 1'b1, 1'b1, adr, 1'b0, 8'h00);
    tick();
    exp_q.push_back(sel ? model[adr] : 8'hFF);
    applyStimulus(1'b0, iom, 1'b0, 1'b1, adr, 1'b0, 8'h00);
    tick();
    expd = exp_q.pop_front();
    for (int k = 0; k < 4; k++) begin
      checkOutput({tag, " ad"}, AD, expd);
      checkOutput({tag, " rd rdy"}, {7'd0, RDY}, {7'd0, sel ? expRdy(k) : 1'b1});
      tick();
    end
    RD = 1'b1;
    #1;
    checkOutput({tag, " ad release"}, AD, 8'hFF);
    tick();
  endtask

  initial begin
    logic [7:0] expd;
    RESET = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 20'h00000, 1'b0, 8'h00);
    tick();
    tick();
    checkOutput("reset ad", AD, 8'hFF);
    checkOutput("reset rdy", {7'd0, RDY}, 8'h01);
    RESET = 1'b0;
    tick();
    checkOutput("post reset ad", AD, 8'hFF);
    checkOutput("post reset rdy", {7'd0, RDY}, 8'h01);

    $display("[TB] write then read");
    doWrite(20'h00123, 1'b0, 8'h5A, 1'b1, "w123");
    doRead (20'h00123, 1'b0, 1'b1, "r123");
    doWrite(20'h00200, 1'b0, 8'h3C, 1'b1, "w200");
    doWrite(20'h003FF, 1'b0, 8'h81, 1'b1, "w3ff");
    doRead (20'h00200, 1'b0, 1'b1, "r200");
    doRead (20'h003FF, 1'b0, 1'b1, "r3ff");
    doRead (20'h00123, 1'b0, 1'b1, "r123b");

    $display("[TB] decode");
    doWrite(20'h00123, 1'b1, 8'hEE, 1'b0, "io w123");
    doWrite(20'h00523, 1'b0, 8'h77, 1'b0, "oow w523");
    doRead (20'h00123, 1'b1, 1'b0, "io r123");
    doRead (20'h00523, 1'b0, 1'b0, "oow r523");
    doRead (20'h00123, 1'b0, 1'b1, "r123 after decode");

    $display("[TB] abort");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 20'h00123, 1'b1, 8'h23);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 20'h00123, 1'b1, 8'hC3);
    tick();
    tick();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 20'h00123, 1'b1, 8'h23);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 20'h00123, 1'b0, 8'h00);
    tick();
    checkOutput("abort addr rdy", {7'd0, RDY}, 8'h01);
    checkOutput("abort addr ad", AD, 8'hFF);
    exp_q.push_back(model[20'h00123]);
    RD = 1'b0;
    tick();
    expd = exp_q.pop_front();
    checkOutput("abort read ad", AD, expd);
    RD = 1'b1;
    tick();
    doRead (20'h00123, 1'b0, 1'b1, "r123 after abort");

    $display("[TB] reset mid-read");
    doWrite(20'h00045, 1'b0, 8'hA5, 1'b1, "w045");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 20'h00045, 1'b1, 8'h45);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 20'h00045, 1'b0, 8'h00);
    tick();
    exp_q.push_back(model[20'h00045]);
    RD = 1'b0;
    tick();
    expd = exp_q.pop_front();
    checkOutput("pre reset ad", AD, expd);
    #1;
    RESET = 1'b1;
    #1;
    checkOutput("mid reset ad", AD, 8'hFF);
    checkOutput("mid reset rdy", {7'd0, RDY}, 8'h01);
    tick();
    RESET = 1'b0;
    tick();
    tick();
    checkOutput("idle after reset ad", AD, 8'hFF);
    checkOutput("idle after reset rdy", {7'd0, RDY}, 8'h01);
    RD = 1'b1;
    tick();
    doRead (20'h00045, 1'b0, 1'b1, "r045 after reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
